pcileech_sysctl: RTL
====================

Name: pcileech_sysctl

Overview:
- Parametrised board system-control block: power-on reset stretcher, free-running 64-bit tick counter, N-channel button synchroniser and debouncer with press/release/long-press detection, and power-on LED blink overlay.
- Instantiated once per board top, ahead of the com, fifo and pcie blocks. It drives their system reset, config-reload request and status LEDs.
- Generalises the per-top ad-hoc tick, reset and LED logic with debounce and multi-button support.

Parameters:
- NUM_BTN, 2, number of raw buttons (1..8).
- NUM_LED, 2, number of LED channels (1..8).
- RST_BTN, 1, index of the button that holds system reset and clears tick.
- BLINK_BTN, 0, index of the button that inverts the LED overlay while pressed.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required for a level change (>=1).
- LONGPRESS_CYCLES, 500000000, held cycles required for long-press (>=1).
- RST_STRETCH_CYCLES, 64, tick value below which rst_out stays asserted.
- BLINK_BIT, 24, tick bit used as the blink square wave.
- BLINK_WINDOW_BIT, 27, blink is active while tick[63:BLINK_WINDOW_BIT]==0.
- LED_BLINK_MASK, 2'b10, per-LED enable for the blink overlay.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- btn_n  in  NUM_BTN  raw asynchronous buttons, active-low
- led_in  in  NUM_LED  LED state from functional blocks
- led_out  out  NUM_LED  LED drive after overlay
- tickcount64  out  64  free-running cycle count
- rst_out  out  1  active-high system reset to downstream blocks
- btn_level  out  NUM_BTN  debounced state, 1=pressed
- btn_press  out  NUM_BTN  1-cycle pulse on debounced press
- btn_release  out  NUM_BTN  1-cycle pulse on debounced release
- btn_long  out  NUM_BTN  1-cycle pulse when hold count reaches LONGPRESS_CYCLES
- btn_long_lvl  out  NUM_BTN  level, high while held >= LONGPRESS_CYCLES (cfg-reload source)

Behaviour:
- Reset (rst_n=0), asynchronous:
  - sync flops = 1 (released); debounce and hold counters = 0; btn_level = 0; all pulses = 0; btn_long_lvl = 0.
  - tickcount64 = 0, so rst_out = 1 combinationally from the tick compare.
- Synchroniser: each btn_n passes through 2 FFs, then is inverted to s[i] (1=pressed).
- Debounce, per button:
  - If s[i] != btn_level[i], the counter increments. If equal, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with s still differing, btn_level toggles next edge and the counter clears.
  - Latency from raw edge to btn_level = 2 + DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES is fully rejected.
- btn_press / btn_release: registered, asserted the cycle after the btn_level 0->1 / 1->0 change, exactly one cycle.
- Hold FSM, per button, states IDLE, HELD, LONG:
  - IDLE -> HELD on btn_level rise; hold counter = 0.
  - HELD: counter increments each cycle. When counter == LONGPRESS_CYCLES-1, go to LONG with btn_long pulse 1 cycle and btn_long_lvl = 1.
  - LONG: counter saturates, no further pulses.
  - Any state -> IDLE on btn_level fall; btn_long_lvl = 0 the same edge.
  - Release and long threshold in the same cycle: release wins, no btn_long.
- Hold counter width: $clog2(LONGPRESS_CYCLES+1). Debounce counter width: $clog2(DEBOUNCE_CYCLES+1).
- tickcount64:
  - Increments by 1 each cycle. Cleared to 0 every cycle btn_level[RST_BTN]=1.
  - Wraps 2^64-1 -> 0. Wrap is not reachable in practice and carries no special handling.
- rst_out = btn_level[RST_BTN] | (tickcount64 < RST_STRETCH_CYCLES).
  - Combinational from registers, glitch-free (single compare of a register).
  - After reset deassert: rst_out high for exactly RST_STRETCH_CYCLES cycles, then low.
  - Releasing RST_BTN restarts the stretch from tick 0.
- LED overlay:
  - blink = tick[BLINK_BIT] & (tick[63:BLINK_WINDOW_BIT]==0).
  - ovl = blink ^ btn_level[BLINK_BTN].
  - led_out[i] = led_in[i] ^ (LED_BLINK_MASK[i] & ovl). Combinational; led_out = led_in when the mask bit is 0.
- Button held through reset: after rst_n rise, sampled pressed after 2 + DEBOUNCE_CYCLES cycles, then btn_press fires normally.

Test Plan:
Bench parameters: DEBOUNCE=4, LONGPRESS=20, STRETCH=8, BLINK_BIT=2, WINDOW_BIT=5, RST_BTN=1, BLINK_BTN=0, mask=2'b10.
1. Release rst_n with buttons up -> rst_out=1 for cycles 0..7, 0 from tick=8; tickcount64 increments 1/cycle; btn_level=0, no pulses.
2. btn_n[0] low for 3 cycles, then high -> no level change, no pulses. Held low 10 cycles -> btn_level[0]=1 at raw+6, btn_press[0] one cycle at raw+7.
3. Hold btn_n[0] low 40 cycles -> btn_long[0] single pulse 20 cycles after level rise; btn_long_lvl high until release; on release btn_release[0] once, btn_long_lvl=0; exactly one btn_long pulse.
4. Press RST_BTN mid-run (tick~100) -> tick held 0 and rst_out=1 while pressed; after debounced release rst_out stays 1 for 8 more cycles.
5. led_in=2'b11, no buttons -> led_out[0]=1 always. led_out[1] toggles every 4 cycles while tick<32, then steady 1. Pressing BLINK_BTN after tick>=32 -> led_out[1]=0.
6. Assert rst_n=0 mid long-press -> all outputs to reset values immediately (asynchronously); rst_out=1; no pulse emitted on reset exit.

Source files
------------

// File: rtl/pcileech_sysctl.sv
// Board system control: reset stretcher, tick counter, button
// debounce with press/release/long-press events and LED blink overlay.
module pcileech_sysctl #(
    parameter int NUM_BTN            = 2,
    parameter int NUM_LED            = 2,
    parameter int RST_BTN            = 1,
    parameter int BLINK_BTN          = 0,
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int LONGPRESS_CYCLES   = 500000000,
    parameter int RST_STRETCH_CYCLES = 64,
    parameter int BLINK_BIT          = 24,
    parameter int BLINK_WINDOW_BIT   = 27,
    parameter logic [NUM_LED-1:0] LED_BLINK_MASK = NUM_LED'(2'b10)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_n,
    input  logic [NUM_LED-1:0] led_in,
    output logic [NUM_LED-1:0] led_out,
    output logic [63:0]        tickcount64,
    output logic               rst_out,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long,
    output logic [NUM_BTN-1:0] btn_long_lvl
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONGPRESS_CYCLES + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LP_MAX = HW'(LONGPRESS_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HELD = 2'd1;
    localparam logic [1:0] S_LONG = 2'd2;

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [63:0]        tick_q;
    logic               blink, ovl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        logic [DW-1:0] db_q, db_d;
        logic [HW-1:0] hc_q, hc_d;
        logic [1:0]    st_q, st_d;
        logic          lvl_q, lvl_d, dly_q;
        logic          press_q, rel_q, long_q, long_d;
        logic          s, rise, fall;

        assign s = ~sync2_q[g];

        always_comb begin
            db_d  = '0;
            lvl_d = lvl_q;
            if (s != lvl_q) begin
                if (db_q == DB_MAX) lvl_d = s;
                else db_d = db_q + DW'(1);
            end
        end

        assign rise = lvl_d & ~lvl_q;
        assign fall = ~lvl_d & lvl_q;

        // Release takes priority over reaching the long-press threshold
        always_comb begin
            st_d   = st_q;
            hc_d   = hc_q;
            long_d = 1'b0;
            if (fall) begin
                st_d = S_IDLE;
                hc_d = '0;
            end else if (rise) begin
                st_d = S_HELD;
                hc_d = '0;
            end else if (st_q == S_HELD) begin
                if (hc_q == LP_MAX) begin
                    st_d   = S_LONG;
                    long_d = 1'b1;
                end else begin
                    hc_d = hc_q + HW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_q    <= '0;
                hc_q    <= '0;
                st_q    <= S_IDLE;
                lvl_q   <= 1'b0;
                dly_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                db_q    <= db_d;
                hc_q    <= hc_d;
                st_q    <= st_d;
                lvl_q   <= lvl_d;
                dly_q   <= lvl_q;
                press_q <= lvl_q & ~dly_q;
                rel_q   <= ~lvl_q & dly_q;
                long_q  <= long_d;
            end
        end

        assign btn_level[g]    = lvl_q;
        assign btn_press[g]    = press_q;
        assign btn_release[g]  = rel_q;
        assign btn_long[g]     = long_q;
        assign btn_long_lvl[g] = (st_q == S_LONG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_q <= '0;
        else if (btn_level[RST_BTN]) tick_q <= '0;
        else tick_q <= tick_q + 64'd1;
    end

    assign tickcount64 = tick_q;
    assign rst_out = btn_level[RST_BTN] |
                     (tick_q < 64'(RST_STRETCH_CYCLES));

    assign blink = tick_q[BLINK_BIT] & ~|tick_q[63:BLINK_WINDOW_BIT];
    assign ovl   = blink ^ btn_level[BLINK_BTN];
    assign led_out = led_in ^ (LED_BLINK_MASK & {NUM_LED{ovl}});

endmodule
